// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the shared SHA-256 shift/rotate engine.
// Two requester channels (A, B) and one tagged response channel.
interface shift_sequencer_if;
    logic        req_a_valid;
    logic        req_a_ready;
    logic [31:0] req_a_data;
    logic [4:0]  req_a_amt;
    logic [1:0]  req_a_op;
    logic        req_b_valid;
    logic        req_b_ready;
    logic [31:0] req_b_data;
    logic [4:0]  req_b_amt;
    logic [1:0]  req_b_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    modport master (
        output req_a_valid, req_a_data, req_a_amt, req_a_op,
        input  req_a_ready,
        output req_b_valid, req_b_data, req_b_amt, req_b_op,
        input  req_b_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );

    modport slave (
        input  req_a_valid, req_a_data, req_a_amt, req_a_op,
        output req_a_ready,
        input  req_b_valid, req_b_data, req_b_amt, req_b_op,
        output req_b_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin shared multi-cycle shift/rotate engine, one binary pass per cycle.
// Define SHIFT_SEQ_ROTR_EN to build op 11 as ROTR; otherwise it acts as SRL.
module shift_sequencer (
    input  logic               clock,
    input  logic               reset_n,
    shift_sequencer_if.slave   bus,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      stateQ, stateD;
    logic [31:0] dataQ, dataD;
    logic [4:0]  amtQ, amtD;
    logic [1:0]  opQ, opD;
    logic        idQ, idD;
    logic        lastQ, lastD;
    logic        grantA, grantB;
    logic [4:0]  passAmt;
    logic [4:0]  amtLeft;
    logic [31:0] shifted;

    // lastQ=1 means B was granted last, so A wins a tie.
    assign grantA = bus.req_a_valid && (!bus.req_b_valid || lastQ);
    assign grantB = bus.req_b_valid && !grantA;

    always_comb begin
        passAmt = 5'd0;
        unique casez (amtQ)
            5'b1????: passAmt = 5'd16;
            5'b01???: passAmt = 5'd8;
            5'b001??: passAmt = 5'd4;
            5'b0001?: passAmt = 5'd2;
            5'b00001: passAmt = 5'd1;
            default:  passAmt = 5'd0;
        endcase
    end

    assign amtLeft = amtQ & ~passAmt;

    always_comb begin
        shifted = dataQ;
        unique case (opQ)
            2'b00: shifted = dataQ >> passAmt;
            2'b01: shifted = 32'($signed(dataQ) >>> passAmt);
            2'b10: shifted = dataQ << passAmt;
`ifdef SHIFT_SEQ_ROTR_EN
            2'b11: shifted = (dataQ >> passAmt)
                           | (dataQ << (6'd32 - {1'b0, passAmt}));
`else
            2'b11: shifted = dataQ >> passAmt;
`endif
        endcase
    end

    always_comb begin
        stateD          = stateQ;
        dataD           = dataQ;
        amtD            = amtQ;
        opD             = opQ;
        idD             = idQ;
        lastD           = lastQ;
        bus.req_a_ready = 1'b0;
        bus.req_b_ready = 1'b0;
        unique case (stateQ)
            IDLE: begin
                bus.req_a_ready = reset_n && grantA;
                bus.req_b_ready = reset_n && grantB;
                if (grantA || grantB) begin
                    dataD  = grantA ? bus.req_a_data : bus.req_b_data;
                    amtD   = grantA ? bus.req_a_amt : bus.req_b_amt;
                    opD    = grantA ? bus.req_a_op : bus.req_b_op;
                    idD    = grantB;
                    lastD  = grantB;
                    stateD = (amtD != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                dataD = shifted;
                amtD  = amtLeft;
                if (amtLeft == 5'd0) stateD = DONE;
            end
            DONE: begin
                if (bus.resp_ready) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= IDLE;
            dataQ  <= '0;
            amtQ   <= '0;
            opQ    <= '0;
            idQ    <= 1'b0;
            lastQ  <= 1'b1;
        end else begin
            stateQ <= stateD;
            dataQ  <= dataD;
            amtQ   <= amtD;
            opQ    <= opD;
            idQ    <= idD;
            lastQ  <= lastD;
        end
    end

    assign bus.resp_valid = (stateQ == DONE);
    assign bus.resp_data  = dataQ;
    assign bus.resp_id    = idQ;
    assign busy           = (stateQ != IDLE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: latency, data, id, fairness, reset.
// Honours SHIFT_SEQ_ROTR_EN for the expected ROTR behaviour.
module tb_shift_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    shift_sequencer_if bus();

    shift_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          lat;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accCyc = 0;
    int          respCount = 0;
    int          doneCnt = 0;
    bit          respSeen = 1'b0;
    logic [31:0] expA = '0;
    logic [31:0] expB = '0;
    exp_t        sbq[$];
    int          grants[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [4:0] amt,
                                          input logic [1:0] op);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(amt); i++) begin
            case (op)
                2'b00: r = {1'b0, r[31:1]};
                2'b01: r = {r[31], r[31:1]};
                2'b10: r = {r[30:0], 1'b0};
`ifdef SHIFT_SEQ_ROTR_EN
                default: r = {r[0], r[31:1]};
`else
                default: r = {1'b0, r[31:1]};
`endif
            endcase
        end
        return r;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.req_a_valid && bus.req_a_ready) begin
                sbq.push_back('{1'b0, expA, 1 + $countones(bus.req_a_amt)});
                grants.push_back(0);
                accCyc = cyc;
            end
            if (bus.req_b_valid && bus.req_b_ready) begin
                sbq.push_back('{1'b1, expB, 1 + $countones(bus.req_b_amt)});
                grants.push_back(1);
                accCyc = cyc;
            end
            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    if (!respSeen) begin
                        respSeen = 1'b1;
                        check("latency", 32'(cyc - accCyc), 32'(sbq[0].lat));
                    end
                    check("resp_data", bus.resp_data, sbq[0].data);
                    check("resp_id", 32'(bus.resp_id), 32'(sbq[0].id));
                    check("no_accept",
                          {30'b0, bus.req_a_ready, bus.req_b_ready}, 32'd0);
                    if (bus.resp_ready) begin
                        void'(sbq.pop_front());
                        respSeen = 1'b0;
                        respCount++;
                    end
                end
            end
        end
    end

    task automatic idleInputs();
        bus.req_a_valid = 1'b0;
        bus.req_a_data  = '0;
        bus.req_a_amt   = '0;
        bus.req_a_op    = '0;
        bus.req_b_valid = 1'b0;
        bus.req_b_data  = '0;
        bus.req_b_amt   = '0;
        bus.req_b_op    = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_a_ready"}, 32'(bus.req_a_ready), 32'd0);
        check({tag, "_b_ready"}, 32'(bus.req_b_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_data"}, bus.resp_data, 32'd0);
        check({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic setReq(input bit id, input logic [31:0] d,
                          input logic [4:0] a, input logic [1:0] op);
        if (!id) begin
            expA = model(d, a, op);
            bus.req_a_data  = d;
            bus.req_a_amt   = a;
            bus.req_a_op    = op;
            bus.req_a_valid = 1'b1;
        end else begin
            expB = model(d, a, op);
            bus.req_b_data  = d;
            bus.req_b_amt   = a;
            bus.req_b_op    = op;
            bus.req_b_valid = 1'b1;
        end
    endtask

    task automatic send(input bit id, input logic [31:0] d,
                        input logic [4:0] a, input logic [1:0] op,
                        input logic [31:0] e);
        int n;
        @(posedge clock);
        #1;
        setReq(id, d, a, op);
        if (!id) expA = e;
        else expB = e;
        n = 0;
        while (1) begin
            @(negedge clock);
            if (!id && bus.req_a_ready) break;
            if (id && bus.req_b_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
        if (!id) bus.req_a_valid = 1'b0;
        else bus.req_b_valid = 1'b0;
    endtask

    task automatic waitResp(input int target);
        int n;
        n = 0;
        while (respCount < target) begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                check("resp_timeout", 32'(respCount), 32'(target));
                break;
            end
        end
    endtask

    initial begin
        logic        rid;
        logic [31:0] rd;
        logic [4:0]  ra;
        logic [1:0]  rop;
        int          n;

        idleInputs();
        bus.resp_ready = 1'b1;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        send(1'b0, 32'h80000000, 5'd4, 2'b01, 32'hF8000000);
        waitResp(++doneCnt);
        send(1'b1, 32'h12345678, 5'd0, 2'b10, 32'h12345678);
        waitResp(++doneCnt);
`ifdef SHIFT_SEQ_ROTR_EN
        send(1'b0, 32'h00000001, 5'd7, 2'b11, 32'h02000000);
`else
        send(1'b0, 32'h00000001, 5'd7, 2'b11, 32'h00000000);
`endif
        waitResp(++doneCnt);
        send(1'b0, 32'h00000003, 5'd31, 2'b10, 32'h80000000);
        waitResp(++doneCnt);

        for (int i = 0; i < 16; i++) begin
            rid = 1'($urandom_range(0, 1));
            rd  = $urandom;
            ra  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            send(rid, rd, ra, rop, model(rd, ra, rop));
            waitResp(++doneCnt);
        end

        // B last, so the following tie must go A first.
        send(1'b1, 32'hDEADBEEF, 5'd9, 2'b01, model(32'hDEADBEEF, 5'd9, 2'b01));
        waitResp(++doneCnt);

        bus.resp_ready = 1'b0;
        grants.delete();
        @(posedge clock);
        #1;
        setReq(1'b0, 32'hA5A5A5A5, 5'd3, 2'b10);
        setReq(1'b1, 32'h80000001, 5'd1, 2'b11);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (1) begin
                @(negedge clock);
                if (bus.resp_valid) break;
                n++;
                if (n > 50) begin
                    check("fair_timeout", 32'(k), 32'd4);
                    break;
                end
            end
            repeat (5) @(posedge clock);
            #1;
            bus.resp_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.resp_ready = 1'b0;
            if (k == 3) begin
                bus.req_a_valid = 1'b0;
                bus.req_b_valid = 1'b0;
            end
        end
        doneCnt += 4;
        waitResp(doneCnt);
        check("grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check("grant_order", 32'(grants[i]), 32'(i % 2));

        bus.resp_ready = 1'b1;
        send(1'b0, 32'h0F0F0F0F, 5'd7, 2'b00, 32'h001E1E1E);
        check("busy_shift", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sbq.delete();
        respSeen = 1'b0;
        grants.delete();
        setReq(1'b0, 32'h00F00000, 5'd4, 2'b00);
        setReq(1'b1, 32'h00000F00, 5'd4, 2'b10);
        #1;
        checkResetOutputs("heldreset");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (grants.size() < 2) begin
            @(negedge clock);
            n++;
            if (n > 50) begin
                check("post_reset_timeout", 32'(grants.size()), 32'd2);
                break;
            end
        end
        @(posedge clock);
        #1;
        idleInputs();
        if (grants.size() > 0)
            check("post_reset_first", 32'(grants[0]), 32'd0);
        doneCnt += 2;
        waitResp(doneCnt);
        check("resp_total", 32'(respCount), 32'(doneCnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
